main_memory_ctrl: RTL and testbench
===================================

// Module: main_memory_ctrl
// PURPOSE
//  Parametrised successor to the fixed main memory: word-addressed RAM behind a RD/WR/ACK handshake.
//  Adds programmable wait states, address-range and protocol error reporting, and a busy flag.
//  Sits between Centro_Control (RD/WR/ACK), bus A (address) and bus B (write data).
//  Read data goes to the bus-C memory/ALU mux.
// PARAMETERS
//  DATAWIDTH_BUS    32  data and address bus width
//  MEM_DEPTH       256  number of words; power of 2, >=2
//  WAIT_STATES       2  extra cycles between request sample and ACK (0..15)
// PORTS
//  MEM_CTRL_CLOCK_50        in   1              system clock
//  MEM_CTRL_RESET_InLow     in   1              synchronous reset, active low
//  MEM_CTRL_RD_In           in   1              read request, level, held until ACK
//  MEM_CTRL_WR_In           in   1              write request, level, held until ACK
//  MEM_CTRL_ADDRESS_InBUS   in   DATAWIDTH_BUS  word address (bus A)
//  MEM_CTRL_data_InBUS      in   DATAWIDTH_BUS  write data (bus B)
//  MEM_CTRL_data_OutBUS     out  DATAWIDTH_BUS  registered read data
//  MEM_CTRL_ACK_Out         out  1              one-cycle completion pulse
//  MEM_CTRL_ERR_Out         out  1              valid only with ACK; 1 = access rejected
//  MEM_CTRL_BUSY_Out        out  1              1 in any state other than IDLE
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-low (MEM_CTRL_RESET_InLow sampled on rising MEM_CTRL_CLOCK_50).
//  Reset: state=IDLE; data_Out=0; ACK=0; ERR=0; BUSY=0; wait counter=0. RAM contents are not cleared.
//  FSM states: IDLE -> WAIT -> ACK -> RELEASE -> IDLE.
//   IDLE: on RD^WR=1, latch addr/data/op and load counter=WAIT_STATES.
//    Go to WAIT, or to ACK if WAIT_STATES=0.
//   IDLE with RD&WR=1: latch op=PROTO_ERR and go to WAIT. Same latency as a normal access; no RAM access.
//   WAIT: decrement counter; at 0 go to ACK. Request inputs are ignored (latched copy used).
//   ACK: ACK=1 for exactly one cycle.
//    Write: RAM commits on this edge.
//    Read: data_Out updates on this edge.
//    ERR=1 if address[DATAWIDTH_BUS-1:log2(MEM_DEPTH)] != 0 or op=PROTO_ERR.
//    On ERR: no write occurs and data_Out holds its previous value.
//   RELEASE: wait until RD=0 and WR=0, then go to IDLE. Prevents a held request being re-served.
//  Latency: request sampled at edge N -> ACK high during cycle N+WAIT_STATES+1.
//  data_Out holds its value until the next successful read ACK.
//  Reset mid-operation: a write in WAIT is discarded (never committed); ACK is not issued.
//  Address wrap: none. Out-of-range addresses error instead of aliasing.
//  Read-after-write to the same address returns the new data. The write commits before the next request is sampled.
// CONFIGURATION
//  MEM_CTRL_PARITY_EN defined:
//   Each word stores an extra even-parity bit, computed at write.
//   On read, a parity mismatch gives ERR=1, data_Out still updates (raw word), and ACK is issued normally.
//  MEM_CTRL_PARITY_EN undefined: no parity storage; ERR comes from address/protocol checks only.
// STRUCTURE
//  Package mem_ctrl_pkg contains:
//   - state typedef (IDLE, WAIT, ACK, RELEASE)
//   - op typedef (OP_RD, OP_WR, OP_PROTO_ERR)
//   - localparam ADDR_BITS = $clog2(MEM_DEPTH) helper
//  Sub-module mem_ctrl_array: synchronous single-port RAM (optional parity column). Write enable and read strobe are driven by the FSM.
//  Top holds the FSM, wait counter, request latches and error logic.
// TESTING
//  1. WAIT_STATES=2: WR addr 5 data 0xDEADBEEF, then RD addr 5.
//     -> ACK 3 cycles after each sample; data_Out=0xDEADBEEF; ERR=0.
//  2. WAIT_STATES=0: RD held 4 cycles.
//     -> exactly one ACK pulse; BUSY stays 1 until RD drops, then 0 next cycle.
//  3. MEM_DEPTH=256: RD addr 0x100.
//     -> ACK with ERR=1; data_Out unchanged from the previous read.
//  4. RD=WR=1 with addr 3 data 0x1.
//     -> ACK with ERR=1; a later RD of addr 3 returns its previous contents.
//  5. WR addr 7 0x12345678; assert reset during WAIT; then RD addr 7.
//     -> no ACK during reset; old value returned; all outputs 0 in the reset cycle.
//  6. With MEM_CTRL_PARITY_EN: force a parity-bit flip on addr 9, then RD 9.
//     -> ACK with ERR=1; data_Out = stored word.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and address-width helpers for main_memory_ctrl
// Contents: controller state enum, latched operation enum, default depth and address-width helpers.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_RD        = 2'd0,
        OP_WR        = 2'd1,
        OP_PROTO_ERR = 2'd2
    } op_t;

    localparam int DEFAULT_MEM_DEPTH = 256;
    localparam int ADDR_BITS         = $clog2(DEFAULT_MEM_DEPTH);

    function automatic int addr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_ctrl_array.sv
// rtl/mem_ctrl_array.sv - synchronous single-port word RAM with optional parity column
// Optional feature: MEM_CTRL_PARITY_EN adds a stored even-parity bit per word.
// Ports:
//   clk, resetn   clock and synchronous active-low reset (read register and parity flag only)
//   we            write strobe, commits wdata at addr
//   re            read strobe, loads rdata from addr; rdata holds otherwise
//   addr          word address
//   wdata         write data
//   rdata         registered read data
//   parity_err    one-cycle flag registered with a read when the stored parity disagrees
module mem_ctrl_array
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEFAULT_MEM_DEPTH,
    parameter int ADDR_W = ADDR_BITS
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              parity_err
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

`ifdef MEM_CTRL_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            par_mem[addr] <= ^wdata;
        end
    end

    // The raw word is still returned on a mismatch; only the flag reports it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= re && ((^mem[addr]) != par_mem[addr]);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/main_memory_ctrl.sv
// rtl/main_memory_ctrl.sv - word-addressed RAM controller with RD/WR/ACK handshake and wait states
// Optional feature: MEM_CTRL_PARITY_EN (parity column in the RAM, mismatch reported on ERR).
// Ports:
//   MEM_CTRL_CLOCK_50       system clock
//   MEM_CTRL_RESET_InLow    synchronous active-low reset
//   MEM_CTRL_RD_In          read request level, held until ACK
//   MEM_CTRL_WR_In          write request level, held until ACK
//   MEM_CTRL_ADDRESS_InBUS  word address (bus A)
//   MEM_CTRL_data_InBUS     write data (bus B)
//   MEM_CTRL_data_OutBUS    registered read data, held until the next good read
//   MEM_CTRL_ACK_Out        one-cycle completion pulse
//   MEM_CTRL_ERR_Out        access rejected, meaningful only with ACK
//   MEM_CTRL_BUSY_Out       controller not idle
module main_memory_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32,
    parameter int MEM_DEPTH     = DEFAULT_MEM_DEPTH,
    parameter int WAIT_STATES   = 2
) (
    input  logic                     MEM_CTRL_CLOCK_50,
    input  logic                     MEM_CTRL_RESET_InLow,
    input  logic                     MEM_CTRL_RD_In,
    input  logic                     MEM_CTRL_WR_In,
    input  logic [DATAWIDTH_BUS-1:0] MEM_CTRL_ADDRESS_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] MEM_CTRL_data_InBUS,
    output logic [DATAWIDTH_BUS-1:0] MEM_CTRL_data_OutBUS,
    output logic                     MEM_CTRL_ACK_Out,
    output logic                     MEM_CTRL_ERR_Out,
    output logic                     MEM_CTRL_BUSY_Out
);

    localparam int         ADDR_W    = addr_bits(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t                   state;
    op_t                      op_q;
    logic [3:0]               wait_cnt;
    logic [DATAWIDTH_BUS-1:0] addr_q;
    logic [DATAWIDTH_BUS-1:0] data_q;
    logic                     ack_q;
    logic                     err_q;
    logic                     busy_q;

    logic range_err;
    logic access_ok;
    logic ram_we;
    logic ram_re;
    logic parity_err;

    // Any bit above the RAM index means the access is rejected, never aliased.
    assign range_err = |addr_q[DATAWIDTH_BUS-1:ADDR_W];

    // RAM is touched only on the ACK edge of a clean access; reset blocks it.
    assign access_ok = MEM_CTRL_RESET_InLow && (state == ACK) &&
                       (op_q != OP_PROTO_ERR) && !range_err;
    assign ram_we    = access_ok && (op_q == OP_WR);
    assign ram_re    = access_ok && (op_q == OP_RD);

    always_ff @(posedge MEM_CTRL_CLOCK_50) begin
        if (!MEM_CTRL_RESET_InLow) begin
            state    <= IDLE;
            op_q     <= OP_RD;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            data_q   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (MEM_CTRL_RD_In || MEM_CTRL_WR_In) begin
                        addr_q   <= MEM_CTRL_ADDRESS_InBUS;
                        data_q   <= MEM_CTRL_data_InBUS;
                        wait_cnt <= WAIT_LOAD;
                        busy_q   <= 1'b1;
                        if (MEM_CTRL_RD_In && MEM_CTRL_WR_In) begin
                            op_q <= OP_PROTO_ERR;
                        end else if (MEM_CTRL_RD_In) begin
                            op_q <= OP_RD;
                        end else begin
                            op_q <= OP_WR;
                        end
                        state <= (WAIT_LOAD == 4'd0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    // Leaving when the counter reaches 0 keeps ACK at WAIT_STATES+1 after sampling.
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    ack_q <= 1'b1;
                    err_q <= (op_q == OP_PROTO_ERR) || range_err;
                    state <= RELEASE;
                end
                RELEASE: begin
                    // A still-held request must not be served a second time.
                    if (!MEM_CTRL_RD_In && !MEM_CTRL_WR_In) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    mem_ctrl_array #(
        .DATA_W (DATAWIDTH_BUS),
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk        (MEM_CTRL_CLOCK_50),
        .resetn     (MEM_CTRL_RESET_InLow),
        .we         (ram_we),
        .re         (ram_re),
        .addr       (addr_q[ADDR_W-1:0]),
        .wdata      (data_q),
        .rdata      (MEM_CTRL_data_OutBUS),
        .parity_err (parity_err)
    );

    assign MEM_CTRL_ACK_Out  = ack_q;
    assign MEM_CTRL_ERR_Out  = err_q | parity_err;
    assign MEM_CTRL_BUSY_Out = busy_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// tb/tb_main_memory_ctrl.sv - directed self-checking bench for main_memory_ctrl
module tb_main_memory_ctrl;

    logic        clk;
    logic        resetn;

    logic        rd_a, wr_a;
    logic [31:0] addr_a, wdata_a, dout_a;
    logic        ack_a, err_a, busy_a;

    logic        rd_b, wr_b;
    logic [31:0] addr_b, wdata_b, dout_b;
    logic        ack_b, err_b, busy_b;

    int          n_cmp;
    int          n_fail;
    int          lat;
    int          acks;
    logic        err_s;
    logic        busy_s;
    logic [31:0] exp_dout;

    main_memory_ctrl #(.DATAWIDTH_BUS(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut_a (
        .MEM_CTRL_CLOCK_50      (clk),
        .MEM_CTRL_RESET_InLow   (resetn),
        .MEM_CTRL_RD_In         (rd_a),
        .MEM_CTRL_WR_In         (wr_a),
        .MEM_CTRL_ADDRESS_InBUS (addr_a),
        .MEM_CTRL_data_InBUS    (wdata_a),
        .MEM_CTRL_data_OutBUS   (dout_a),
        .MEM_CTRL_ACK_Out       (ack_a),
        .MEM_CTRL_ERR_Out       (err_a),
        .MEM_CTRL_BUSY_Out      (busy_a)
    );

    main_memory_ctrl #(.DATAWIDTH_BUS(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut_b (
        .MEM_CTRL_CLOCK_50      (clk),
        .MEM_CTRL_RESET_InLow   (resetn),
        .MEM_CTRL_RD_In         (rd_b),
        .MEM_CTRL_WR_In         (wr_b),
        .MEM_CTRL_ADDRESS_InBUS (addr_b),
        .MEM_CTRL_data_InBUS    (wdata_b),
        .MEM_CTRL_data_OutBUS   (dout_b),
        .MEM_CTRL_ACK_Out       (ack_b),
        .MEM_CTRL_ERR_Out       (err_b),
        .MEM_CTRL_BUSY_Out      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request on dut_a from posedge+1, observes 12 edges, then drops it.
    // lat is counted in edges after the sample edge (sample edge = 0).
    task automatic req_a(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
        rd_a = rd; wr_a = wr; addr_a = addr; wdata_a = data;
        lat = -1; acks = 0; err_s = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ack_a) begin
                if (lat < 0) begin
                    lat   = k;
                    err_s = err_a;
                end
                acks++;
            end
        end
        busy_s = busy_a;
        rd_a = 1'b0; wr_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        rd_a = 0; wr_a = 0; addr_a = 0; wdata_a = 0;
        rd_b = 0; wr_b = 0; addr_b = 0; wdata_b = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL reset_ack_a: got %b want 0", ack_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err_a: got %b want 0", err_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
        n_cmp++; if (dout_a !== 32'h0) begin n_fail++; $display("FAIL reset_dout_a: got %h want 0", dout_a); end
        n_cmp++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
        n_cmp++; if (dout_b !== 32'h0) begin n_fail++; $display("FAIL reset_dout_b: got %h want 0", dout_b); end
        resetn = 1'b1;
        exp_dout = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        req_a(1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL wr5_latency: got %0d want 3", lat); end
        n_cmp++; if (acks != 1) begin n_fail++; $display("FAIL wr5_ack_count: got %0d want 1", acks); end
        n_cmp++; if (err_s !== 1'b0) begin n_fail++; $display("FAIL wr5_err: got %b want 0", err_s); end
        n_cmp++; if (busy_s !== 1'b1) begin n_fail++; $display("FAIL wr5_busy_held: got %b want 1", busy_s); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL wr5_busy_released: got %b want 0", busy_a); end
        n_cmp++; if (dout_a !== exp_dout) begin n_fail++; $display("FAIL wr5_dout_hold: got %h want %h", dout_a, exp_dout); end
        req_a(1'b1, 1'b0, 32'd5, 32'h0);
        exp_dout = 32'hDEADBEEF;
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL rd5_latency: got %0d want 3", lat); end
        n_cmp++; if (err_s !== 1'b0) begin n_fail++; $display("FAIL rd5_err: got %b want 0", err_s); end
        n_cmp++; if (dout_a !== exp_dout) begin n_fail++; $display("FAIL rd5_data: got %h want %h", dout_a, exp_dout); end
    endtask

    task automatic test_hold_ws0();
        rd_b = 0; wr_b = 1; addr_b = 32'd2; wdata_b = 32'hA5A5A5A5;
        lat = -1; acks = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ack_b) begin if (lat < 0) lat = k; acks++; end
        end
        n_cmp++; if (acks != 1) begin n_fail++; $display("FAIL ws0_wr_ack_count: got %0d want 1", acks); end
        wr_b = 0;
        @(posedge clk); #1;
        rd_b = 1; addr_b = 32'd2;
        lat = -1; acks = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ack_b) begin if (lat < 0) begin lat = k; err_s = err_b; end acks++; end
        end
        n_cmp++; if (acks != 1) begin n_fail++; $display("FAIL ws0_rd_ack_count: got %0d want 1", acks); end
        n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL ws0_rd_latency: got %0d want 1", lat); end
        n_cmp++; if (err_s !== 1'b0) begin n_fail++; $display("FAIL ws0_rd_err: got %b want 0", err_s); end
        n_cmp++; if (dout_b !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL ws0_rd_data: got %h want a5a5a5a5", dout_b); end
        n_cmp++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL ws0_busy_held: got %b want 1", busy_b); end
        rd_b = 0;
        @(posedge clk); #1;
        n_cmp++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL ws0_busy_drop: got %b want 0", busy_b); end
    endtask

    task automatic test_out_of_range();
        req_a(1'b1, 1'b0, 32'h100, 32'h0);
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL oor100_latency: got %0d want 3", lat); end
        n_cmp++; if (err_s !== 1'b1) begin n_fail++; $display("FAIL oor100_err: got %b want 1", err_s); end
        n_cmp++; if (dout_a !== exp_dout) begin n_fail++; $display("FAIL oor100_dout_hold: got %h want %h", dout_a, exp_dout); end
        req_a(1'b0, 1'b1, 32'h8000_0005, 32'h55555555);
        n_cmp++; if (err_s !== 1'b1) begin n_fail++; $display("FAIL oor_msb_wr_err: got %b want 1", err_s); end
        req_a(1'b1, 1'b0, 32'd5, 32'h0);
        n_cmp++; if (dout_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL oor_no_alias: got %h want deadbeef", dout_a); end
        req_a(1'b0, 1'b1, 32'hFF, 32'h0BADF00D);
        n_cmp++; if (err_s !== 1'b0) begin n_fail++; $display("FAIL top_addr_wr_err: got %b want 0", err_s); end
        req_a(1'b1, 1'b0, 32'hFF, 32'h0);
        exp_dout = 32'h0BADF00D;
        n_cmp++; if (err_s !== 1'b0) begin n_fail++; $display("FAIL top_addr_rd_err: got %b want 0", err_s); end
        n_cmp++; if (dout_a !== exp_dout) begin n_fail++; $display("FAIL top_addr_rd_data: got %h want %h", dout_a, exp_dout); end
    endtask

    task automatic test_proto_err();
        req_a(1'b0, 1'b1, 32'd3, 32'h11223344);
        req_a(1'b1, 1'b1, 32'd3, 32'h00000001);
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL proto_latency: got %0d want 3", lat); end
        n_cmp++; if (err_s !== 1'b1) begin n_fail++; $display("FAIL proto_err: got %b want 1", err_s); end
        n_cmp++; if (dout_a !== exp_dout) begin n_fail++; $display("FAIL proto_dout_hold: got %h want %h", dout_a, exp_dout); end
        req_a(1'b1, 1'b0, 32'd3, 32'h0);
        exp_dout = 32'h11223344;
        n_cmp++; if (dout_a !== exp_dout) begin n_fail++; $display("FAIL proto_no_write: got %h want %h", dout_a, exp_dout); end
    endtask

    task automatic test_reset_mid();
        req_a(1'b0, 1'b1, 32'd7, 32'hCAFEF00D);
        rd_a = 0; wr_a = 1; addr_a = 32'd7; wdata_a = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b0; wr_a = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack: got %b want 0", ack_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b want 0", err_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy_a); end
        n_cmp++; if (dout_a !== 32'h0) begin n_fail++; $display("FAIL rstmid_dout: got %h want 0", dout_a); end
        resetn = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_late_ack: got %b want 0", ack_a); end
        req_a(1'b1, 1'b0, 32'd7, 32'h0);
        exp_dout = 32'hCAFEF00D;
        n_cmp++; if (dout_a !== exp_dout) begin n_fail++; $display("FAIL rstmid_old_value: got %h want %h", dout_a, exp_dout); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h00000001; vals[1] = 32'hFFFFFFFF;
        vals[2] = 32'h80000000; vals[3] = 32'h7E57C0DE;
        for (int i = 0; i < 4; i++) begin
            req_a(1'b0, 1'b1, 32'(20 + i), vals[i]);
        end
        for (int i = 3; i >= 0; i--) begin
            req_a(1'b1, 1'b0, 32'(20 + i), 32'h0);
            exp_dout = vals[i];
            n_cmp++; if (dout_a !== exp_dout) begin n_fail++; $display("FAIL b2b_rd_%0d: got %h want %h", 20 + i, dout_a, exp_dout); end
        end
    endtask

`ifdef MEM_CTRL_PARITY_EN
    task automatic test_parity();
        req_a(1'b0, 1'b1, 32'd9, 32'h0F0F0F0F);
        dut_a.u_array.par_mem[9] = ~dut_a.u_array.par_mem[9];
        req_a(1'b1, 1'b0, 32'd9, 32'h0);
        exp_dout = 32'h0F0F0F0F;
        n_cmp++; if (acks != 1) begin n_fail++; $display("FAIL parity_ack_count: got %0d want 1", acks); end
        n_cmp++; if (err_s !== 1'b1) begin n_fail++; $display("FAIL parity_err: got %b want 1", err_s); end
        n_cmp++; if (dout_a !== exp_dout) begin n_fail++; $display("FAIL parity_raw_data: got %h want %h", dout_a, exp_dout); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_write_read();
        test_hold_ws0();
        test_out_of_range();
        test_proto_err();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_CTRL_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
